lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: takes one request at a time from the pipeline,
// runs a single memory transaction, and returns an extended load result.
// Optional mem_ack timeout is compiled in when LSU_TIMEOUT_EN is defined.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    // Elaboration-time sanity check on the timeout limit
    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

    state_e      state_q;
    logic [2:0]  funct_q;
    logic [1:0]  lane_q;

    logic        acc_ok;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;
    logic            timeout_hit;
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

    // Decode access size: legality, alignment, byte enables and replicated data
    always_comb begin
        acc_ok  = 1'b0;
        be_n    = 4'b0000;
        wdata_n = 32'h0;
        unique case (req_funct)
            3'b000, 3'b100: begin
                acc_ok  = 1'b1;
                be_n    = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                acc_ok  = ~req_addr[0];
                be_n    = 4'b0011 << req_addr[1:0];
                wdata_n = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                acc_ok  = (req_addr[1:0] == 2'b00);
                be_n    = 4'b1111;
                wdata_n = req_wdata;
            end
            default: acc_ok = 1'b0;
        endcase
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        rd_shift = mem_rdata >> {lane_q, 3'b000};
        load_ext = 32'h0;
        unique case (funct_q)
            3'b000:  load_ext = {24'h0, rd_shift[7:0]};
            3'b100:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_ext = {16'h0, rd_shift[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_ready  <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= 32'h0;
            funct_q    <= 3'b000;
            lane_q     <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (acc_ok) begin
                            state_q   <= StMem;
                            mem_req   <= 1'b1;
                            mem_we    <= req_is_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_n;
                            mem_wdata <= wdata_n;
                            funct_q   <= req_funct;
                            lane_q    <= req_addr[1:0];
`ifdef LSU_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                        end else begin
                            // Illegal or misaligned: report without touching memory
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'h0;
                        end
                    end
                end
                StMem: begin
                    if (mem_ack) begin
                        // Ack wins over a timeout landing in the same cycle
                        state_q    <= StResp;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= mem_we ? 32'h0 : load_ext;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_q    <= StResp;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StResp: begin
                    state_q    <= StIdle;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand-written
// corner sequences and randomized transactions against a size/offset model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct    (req_funct),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour from access size, signedness and byte offset
    function automatic void model(input logic st, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output logic err, output logic [3:0] be,
                                  output logic [31:0] wdo, output logic [31:0] data);
        int size;
        bit sgn;
        bit legal;
        int off;
        longint unsigned mask;
        longint unsigned v;
        legal = 1;
        sgn = 0;
        size = 1;
        case (f)
            3'b000: begin size = 1; sgn = 0; end
            3'b100: begin size = 1; sgn = 1; end
            3'b001: begin size = 2; sgn = 1; end
            3'b101: begin size = 2; sgn = 0; end
            3'b010: begin size = 4; sgn = 0; end
            default: legal = 0;
        endcase
        off  = int'(a % 4);
        err  = !legal || ((a % size) != 0);
        mask = (64'd1 << (8 * size)) - 1;
        be   = 4'(((1 << size) - 1) << off);
        wdo  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            wdo = wdo | (32'((wd >> (8 * (i % size))) & 32'hFF) << (8 * i));
        end
        v = (64'(rd) >> (8 * off)) & mask;
        if (sgn && ((v >> (8 * size - 1)) & 1) == 1) v = v | ~mask;
        data = (st || err) ? 32'h0 : 32'(v);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic do_txn(input logic st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int delay,
                          input logic e_err, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic [31:0] e_data);
        wait_ready();
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct    = f;
        req_addr     = a;
        req_wdata    = wd;
        tick();
        req_valid = 1'b0;
        if (e_err) begin
            check("err_no_mem_req", 32'(mem_req), 32'd0);
            check("err_resp_valid", 32'(resp_valid), 32'd1);
            check("err_resp_err", 32'(resp_err), 32'd1);
            check("err_resp_data", resp_data, 32'h0);
            tick();
            check("err_pulse_end", 32'(resp_valid), 32'd0);
            check("err_ready_back", 32'(req_ready), 32'd1);
        end else begin
            check("mem_req_rise", 32'(mem_req), 32'd1);
            check("mem_we", 32'(mem_we), 32'(st));
            check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
            check("mem_be", 32'(mem_be), 32'(e_be));
            if (st) check("mem_wdata", mem_wdata, e_wd);
            check("no_early_resp", 32'(resp_valid), 32'd0);
            for (int i = 0; i < delay; i++) begin
                // Stray requests while busy must not disturb the transaction
                req_valid = 1'b1;
                req_funct = 3'b010;
                req_addr  = $urandom & 32'hFFFF_FFFC;
                mem_ack   = 1'b0;
                tick();
                check("mem_req_hold", 32'(mem_req), 32'd1);
                check("mem_addr_hold", mem_addr, a & 32'hFFFF_FFFC);
                check("mem_be_hold", 32'(mem_be), 32'(e_be));
                check("no_resp_wait", 32'(resp_valid), 32'd0);
            end
            req_valid = 1'b0;
            mem_ack   = 1'b1;
            mem_rdata = rd;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            check("mem_req_drop", 32'(mem_req), 32'd0);
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_err", 32'(resp_err), 32'd0);
            check("resp_data", resp_data, e_data);
            tick();
            check("resp_pulse_end", 32'(resp_valid), 32'd0);
            check("ready_back", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        logic        m_err;
        logic [3:0]  m_be;
        logic [31:0] m_wd;
        logic [31:0] m_data;
        int          n;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct    = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;

        //           st    funct   addr          wdata         rdata     dly err be      wdata         data
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_1000, 32'h0,        32'hABCDEF12, 1, 1'b0, 4'b1111, 32'h0,        32'hABCDEF12};
        vecs[1]  = '{1'b0, 3'b001, 32'h0000_1002, 32'h0,        32'h8234ABCD, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF8234};
        vecs[2]  = '{1'b0, 3'b101, 32'h0000_1002, 32'h0,        32'h8234ABCD, 0, 1'b0, 4'b1100, 32'h0,        32'h00008234};
        vecs[3]  = '{1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FFFF7F, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[4]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FFFF7F, 1, 1'b0, 4'b1000, 32'h0,        32'h00000080};
        vecs[5]  = '{1'b1, 3'b000, 32'h0000_1001, 32'h0000_00A5, 32'h12345678, 0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_1002, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 3'b011, 32'h0000_1000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[8]  = '{1'b0, 3'b001, 32'h0000_1001, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 3'b101, 32'h0000_1002, 32'h1234BEEF, 32'h0,        2, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
        // Ack in the 16th mem_req cycle: completes normally even with the timeout enabled
        vecs[10] = '{1'b1, 3'b010, 32'h0000_2000, 32'hDEADBEEF, 32'h0,       15, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[11] = '{1'b1, 3'b111, 32'h0000_2000, 32'hDEADBEEF, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};

        // Reset state
        #12;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Stray ack while idle produces nothing
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        check("idle_ack_no_resp", 32'(resp_valid), 32'd0);
        check("idle_ack_no_req", 32'(mem_req), 32'd0);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].st, vecs[i].funct, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                   vecs[i].delay, vecs[i].e_err, vecs[i].e_be, vecs[i].e_wdata, vecs[i].e_data);
        end

        // Reset asserted mid-MEM abandons the transaction
        wait_ready();
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct    = 3'b010;
        req_addr     = 32'h0000_3000;
        tick();
        req_valid = 1'b0;
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_mem_be", 32'(mem_be), 32'd0);
        mem_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) mem_ack = 1'b0;
            if (resp_valid) n++;
        end
        check("midrst_no_resp", 32'(n), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // No ack: mem_req must stay up for exactly 16 cycles, then error
        wait_ready();
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct    = 3'b010;
        req_addr     = 32'h0000_4000;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (mem_req && n < 100) begin
            n++;
            tick();
        end
        check("timeout_cycles", 32'(n), 32'd16);
        check("timeout_resp_valid", 32'(resp_valid), 32'd1);
        check("timeout_resp_err", 32'(resp_err), 32'd1);
        check("timeout_resp_data", resp_data, 32'h0);
        tick();
        check("timeout_pulse_end", 32'(resp_valid), 32'd0);
`endif

        // Randomized transactions against the reference model
        for (int i = 0; i < 200; i++) begin
            logic        st;
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rd;
            st = 1'($urandom);
            f  = 3'($urandom);
            a  = $urandom;
            wd = $urandom;
            rd = $urandom;
            model(st, f, a, wd, rd, m_err, m_be, m_wd, m_data);
            do_txn(st, f, a, wd, rd, int'($urandom_range(0, 5)), m_err, m_be, m_wd, m_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
